output_drain: RTL and testbench

Readout engine on the output-buffer host port of the systolic-array top. After the array has written results, it reads a programmed range of 512-bit output rows through the `output_buffer_*` port and streams each row as sixteen 32-bit words on a valid/ready stream toward the host. Two row slots let the next SRAM read overlap serialization, so a stalled-free stream runs at one word per cycle.

---
 rtl/drain_pkg.sv | 33 +++
 rtl/row_serializer.sv | 95 +++++++++
 rtl/output_drain.sv | 135 +++++++++++++
 tb/tb_output_drain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drain_pkg.sv
// drain_pkg: shared constants and types for the output-buffer readout engine.
//   NUM_LANES  words per output row
//   LANE_W     width of one streamed word
//   ADDR_W     output-buffer row address width
//   ROW_W      width of one output-buffer row
//   CNT_W      width of the row-count field (holds 0..2**ADDR_W)
//   row_t      one row viewed as lanes; lane 0 occupies bits [LANE_W-1:0]
//   drain_state_t  readout FSM states
package drain_pkg;

    localparam int NUM_LANES  = 16;
    localparam int LANE_W     = 32;
    localparam int ADDR_W     = 6;
    localparam int ROW_W      = NUM_LANES * LANE_W;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);

    localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(1 << ADDR_W);

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } drain_state_t;

    // A job can never cover more rows than the buffer holds.
    function automatic logic [CNT_W-1:0] clamp_rows(input logic [CNT_W-1:0] n);
        return (n > MAX_ROWS) ? MAX_ROWS : n;
    endfunction

endpackage

// File: rtl/row_serializer.sv
// row_serializer: two-slot row buffer feeding a registered word stream.
//   clk, rst        clock, synchronous active-high reset
//   cap             capture strobe; cap_data is written into the next slot
//   cap_last        captured row is the final row of the job
//   cap_data        row read from the output buffer
//   m_valid/m_ready/m_data/m_last  word stream (registered outputs)
//   slot_free       pulse in the cycle whose lane-15 handshake releases a slot
//   occ             number of occupied slots (including the row being sent)
//
// Stream handshake: a word moves when m_valid and m_ready are both high at a
// rising edge; while m_valid is high and m_ready low, m_data/m_last hold and
// m_valid stays high.
module row_serializer
    import drain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic              cap_last,
    input  row_t              cap_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              slot_free,
    output logic [1:0]        occ
);

    row_t                  slot_data [2];
    logic [1:0]            slot_full;
    logic [1:0]            slot_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [LANE_IDX_W-1:0] lane;
    logic [LANE_IDX_W-1:0] lane_nxt;
    logic                  hs;
    logic                  row_done;
    logic                  head;

    assign hs        = m_valid & m_ready;
    assign row_done  = hs && (lane == LANE_IDX_W'(NUM_LANES - 1));
    assign slot_free = row_done;
    assign lane_nxt  = lane + 1'b1;
    // Slot that supplies the next row: the other slot once the current row ends.
    assign head      = row_done ? ~rd_ptr : rd_ptr;
    assign occ       = {1'b0, slot_full[0]} + {1'b0, slot_full[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            slot_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            lane      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
        end else begin
            if (row_done) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            // The issue logic guarantees the write slot is free here.
            if (cap) begin
                slot_data[wr_ptr] <= cap_data;
                slot_full[wr_ptr] <= 1'b1;
                slot_last[wr_ptr] <= cap_last;
                wr_ptr            <= ~wr_ptr;
            end

            if (m_valid && !row_done) begin
                if (hs) begin
                    lane    <= lane_nxt;
                    m_data  <= slot_data[rd_ptr][lane_nxt];
                    m_last  <= slot_last[rd_ptr] &&
                               (lane == LANE_IDX_W'(NUM_LANES - 2));
                end
            end else if (slot_full[head]) begin
                m_valid <= 1'b1;
                lane    <= '0;
                m_data  <= slot_data[head][0];
                m_last  <= 1'b0;
            end else if (cap && (wr_ptr == head)) begin
                // Row arrives into an empty pipeline: lane 0 goes straight out.
                m_valid <= 1'b1;
                lane    <= '0;
                m_data  <= cap_data[0];
                m_last  <= 1'b0;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/output_drain.sv
// output_drain: reads a range of output-buffer rows and streams them as words.
//   CLK, RESET            clock, synchronous active-high reset
//   START                 job request (ignored while BUSY)
//   BASE_ADDR, ROW_CNT    first row and row count, sampled with START
//   BUSY, DONE            job in progress / one-cycle end-of-job pulse
//   output_buffer_*       SRAM read port (cen/wen active low, ren = port claim)
//   M_VALID/M_READY/M_DATA/M_LAST  word stream toward the host
//   dbg_state             current FSM state
//
// A read is in flight for two cycles: the cycle cen is low and the following
// cycle, when its data is on output_buffer_data and gets captured. Occupied
// slots plus in-flight reads never exceed two.
module output_drain
    import drain_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [CNT_W-1:0]  ROW_CNT,
    output logic              BUSY,
    output logic              DONE,
    output logic              output_buffer_cen,
    output logic              output_buffer_wen,
    output logic              output_buffer_ren,
    output logic [ADDR_W-1:0] output_buffer_addr,
    input  logic [ROW_W-1:0]  output_buffer_data,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [LANE_W-1:0] M_DATA,
    output logic              M_LAST,
    output logic [1:0]        dbg_state
);

    drain_state_t      state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  start_rows;
    logic              rd_s1;
    logic              rd_s1_last;
    logic              rd_s2;
    logic              rd_s2_last;
    logic              slot_free;
    logic [1:0]        occ;
    logic [2:0]        committed;
    logic              can_issue;
    logic              last_hs;

    assign start_rows        = clamp_rows(ROW_CNT);
    assign rd_s1             = ~output_buffer_cen;
    assign output_buffer_wen = 1'b1;
    assign output_buffer_ren = BUSY;
    assign dbg_state         = state;

    // Slots that will be held after this edge if no new read is issued.
    assign committed = {1'b0, occ} + {2'b00, rd_s2} + {2'b00, rd_s1}
                     - {2'b00, slot_free};
    assign can_issue = (issued_q < total_q) && (committed < 3'd2);
    assign last_hs   = M_VALID & M_READY & M_LAST;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= ST_IDLE;
            BUSY               <= 1'b0;
            DONE               <= 1'b0;
            output_buffer_cen  <= 1'b1;
            output_buffer_addr <= '0;
            base_q             <= '0;
            total_q            <= '0;
            issued_q           <= '0;
            rd_s1_last         <= 1'b0;
            rd_s2              <= 1'b0;
            rd_s2_last         <= 1'b0;
        end else begin
            rd_s2             <= rd_s1;
            rd_s2_last        <= rd_s1_last;
            output_buffer_cen <= 1'b1;
            DONE              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (start_rows == '0) begin
                            state <= ST_FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state              <= ST_RUN;
                            BUSY               <= 1'b1;
                            base_q             <= BASE_ADDR;
                            total_q            <= start_rows;
                            output_buffer_cen  <= 1'b0;
                            output_buffer_addr <= BASE_ADDR;
                            issued_q           <= CNT_W'(1);
                            rd_s1_last         <= (start_rows == CNT_W'(1));
                        end
                    end
                end
                ST_RUN: begin
                    if (last_hs) begin
                        state <= ST_FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else if (can_issue) begin
                        output_buffer_cen  <= 1'b0;
                        // 6-bit add wraps 63 -> 0 naturally.
                        output_buffer_addr <= base_q + issued_q[ADDR_W-1:0];
                        issued_q           <= issued_q + 1'b1;
                        rd_s1_last         <= (issued_q == total_q - 1'b1);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    row_serializer u_ser (
        .clk       (CLK),
        .rst       (RESET),
        .cap       (rd_s2),
        .cap_last  (rd_s2_last),
        .cap_data  (output_buffer_data),
        .m_ready   (M_READY),
        .m_valid   (M_VALID),
        .m_data    (M_DATA),
        .m_last    (M_LAST),
        .slot_free (slot_free),
        .occ       (occ)
    );

endmodule

// File: tb/tb_output_drain.sv
// tb_output_drain: randomized self-checking bench for output_drain.
// The SRAM is modelled as a memory array; the expected word stream of each job
// is built directly from the memory contents, base address and clamped count.
module tb_output_drain;
    import drain_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [CNT_W-1:0]  ROW_CNT;
    logic              BUSY;
    logic              DONE;
    logic              output_buffer_cen;
    logic              output_buffer_wen;
    logic              output_buffer_ren;
    logic [ADDR_W-1:0] output_buffer_addr;
    logic [ROW_W-1:0]  sram_q;
    logic              M_VALID;
    logic              M_READY;
    logic [LANE_W-1:0] M_DATA;
    logic              M_LAST;
    logic [1:0]        dbg_state;

    output_drain dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .START              (START),
        .BASE_ADDR          (BASE_ADDR),
        .ROW_CNT            (ROW_CNT),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .output_buffer_cen  (output_buffer_cen),
        .output_buffer_wen  (output_buffer_wen),
        .output_buffer_ren  (output_buffer_ren),
        .output_buffer_addr (output_buffer_addr),
        .output_buffer_data (sram_q),
        .M_VALID            (M_VALID),
        .M_READY            (M_READY),
        .M_DATA             (M_DATA),
        .M_LAST             (M_LAST),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // ---------------- SRAM model ----------------
    logic [ROW_W-1:0] mem [64];
    always @(posedge CLK) begin
        if (!output_buffer_cen) sram_q <= mem[output_buffer_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [LANE_W:0] exp_q[$];   // {last, data}
    int tests = 0;
    int fails = 0;
    int t0 = 0;
    int job_base = 0;
    int exp_rows = 0;
    int reads_seen = 0;
    int words_done = 0;
    int rows_done = 0;
    int done_cnt = 0;
    int done_rel = -1;
    int first_valid_rel = -1;
    int ready_pct = 100;
    bit check_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [LANE_W:0] prev_word;
    logic [LANE_W-1:0] first_word;
    logic [LANE_W-1:0] last_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        int rel;
        if (check_en) begin
            rel = cyc - t0 + 1;
            chk("wen_high", output_buffer_wen, 1);
            chk("ren_eq_busy", output_buffer_ren, BUSY);
            if (!output_buffer_cen) begin
                chk("read_while_busy", BUSY, 1);
                chk("read_row_remaining", reads_seen < exp_rows, 1);
                chk("read_addr", output_buffer_addr, (job_base + reads_seen) % 64);
                chk("read_slot_free", (reads_seen + 1 - rows_done) <= 2, 1);
                reads_seen++;
            end
            if (prev_stall) begin
                chk("stall_valid_held", M_VALID, 1);
                chk("stall_word_held", {M_LAST, M_DATA}, prev_word);
            end
            if (M_VALID) begin
                if (first_valid_rel < 0) first_valid_rel = rel;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("word", {M_LAST, M_DATA}, exp_q[0]);
                    if (M_READY) begin
                        void'(exp_q.pop_front());
                        if (words_done == 0) first_word = M_DATA;
                        last_word = M_DATA;
                        words_done++;
                        if (words_done % NUM_LANES == 0) rows_done++;
                    end
                end
            end
            prev_stall = M_VALID && !M_READY;
            prev_word  = {M_LAST, M_DATA};
            if (DONE) begin
                done_cnt++;
                done_rel = rel;
            end
        end
    end

    // ---------------- host ready driver ----------------
    initial begin
        M_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            M_READY = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup_job(input int base, input int cnt);
        int n;
        n = (cnt > 64) ? 64 : cnt;
        for (int a = 0; a < 64; a++)
            for (int i = 0; i < NUM_LANES; i++)
                mem[a][i*LANE_W +: LANE_W] = {2'b00, 6'(a), 4'h0, 4'(i), 16'($urandom)};
        exp_q.delete();
        for (int k = 0; k < n; k++)
            for (int i = 0; i < NUM_LANES; i++)
                exp_q.push_back({(k == n - 1) && (i == NUM_LANES - 1),
                                 mem[(base + k) % 64][i*LANE_W +: LANE_W]});
        job_base = base;
        exp_rows = n;
        reads_seen = 0;
        words_done = 0;
        rows_done = 0;
        done_cnt = 0;
        done_rel = -1;
        first_valid_rel = -1;
    endtask

    task automatic start_job(input int base, input int cnt);
        @(posedge CLK);
        #1;
        START = 1'b1;
        BASE_ADDR = 6'(base);
        ROW_CNT = 7'(cnt);
        @(posedge CLK);
        #1;
        t0 = cyc;
        START = 1'b0;
    endtask

    // exp_first/exp_done < 0 skip the cycle-exact checks.
    task automatic finish_job(input string tag, input int exp_first, input int exp_done);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 6000) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt > 0, 1);
        repeat (3) @(negedge CLK);
        #1;
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_reads"}, reads_seen, exp_rows);
        chk({tag, "_words"}, words_done, exp_rows * NUM_LANES);
        chk({tag, "_busy_low"}, BUSY, 0);
        chk({tag, "_state_idle"}, dbg_state, 0);
        if (exp_first >= 0 || exp_rows == 0)
            chk({tag, "_first_valid_cycle"}, first_valid_rel, exp_first);
        if (exp_done >= 0)
            chk({tag, "_done_cycle"}, done_rel, exp_done);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_cen"}, output_buffer_cen, 1);
        chk({tag, "_wen"}, output_buffer_wen, 1);
        chk({tag, "_ren"}, output_buffer_ren, 0);
        chk({tag, "_addr"}, output_buffer_addr, 0);
        chk({tag, "_valid"}, M_VALID, 0);
        chk({tag, "_data"}, M_DATA, 0);
        chk({tag, "_last"}, M_LAST, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        RESET = 1'b1;
        START = 1'b0;
        BASE_ADDR = '0;
        ROW_CNT = '0;
        repeat (3) @(negedge CLK);
        chk_reset_values("reset");
        chk("reset_state", dbg_state, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_en = 1'b1;

        // Two rows from address 5, host always ready: exact timing.
        ready_pct = 100;
        setup_job(5, 2);
        start_job(5, 2);
        finish_job("t1", 3, 35);
        chk("t1_first_word_tag", first_word[31:16], 16'h0500);
        chk("t1_last_word_tag", last_word[31:16], 16'h060F);

        // Address wrap 62, 63, 0, 1.
        setup_job(62, 4);
        start_job(62, 4);
        finish_job("t2", 3, 3 + 16 * 4);
        chk("t2_first_word_tag", first_word[31:16], 16'h3E00);
        chk("t2_last_word_tag", last_word[31:16], 16'h010F);

        // Empty job.
        setup_job(9, 0);
        start_job(9, 0);
        finish_job("t3", -1, 1);

        // Heavy backpressure.
        ready_pct = 30;
        setup_job($urandom_range(63), 3);
        start_job(job_base, 3);
        finish_job("t4", -1, -1);

        // START while busy is ignored.
        ready_pct = 60;
        setup_job(10, 3);
        start_job(10, 3);
        repeat (20) @(posedge CLK);
        #1;
        START = 1'b1;
        BASE_ADDR = 6'd40;
        ROW_CNT = 7'd5;
        @(posedge CLK);
        #1;
        START = 1'b1;
        ROW_CNT = 7'd0;
        @(posedge CLK);
        #1;
        START = 1'b0;
        finish_job("t5", -1, -1);

        // Reset mid-job after word 10.
        ready_pct = 100;
        setup_job(20, 3);
        start_job(20, 3);
        k = 0;
        while (words_done < 10 && k < 200) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("t6_reached_word10", words_done >= 10, 1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk_reset_values("t6_after_reset");
        done_cnt = 0;
        repeat (6) @(negedge CLK);
        #1;
        chk("t6_no_done", done_cnt, 0);
        setup_job(33, 2);
        start_job(33, 2);
        finish_job("t6_rerun", 3, 35);

        // Count above 64 clamps to the whole buffer.
        setup_job(7, 100);
        start_job(7, 100);
        finish_job("t7", 3, 3 + 16 * 64);
        chk("t7_rows", exp_rows, 64);

        // Random jobs.
        for (int j = 0; j < 6; j++) begin
            int b;
            int c;
            b = $urandom_range(63);
            c = $urandom_range(8);
            ready_pct = $urandom_range(100, 40);
            setup_job(b, c);
            start_job(b, c);
            finish_job("rnd", -1, -1);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
